// File: rtl/shift_tx_ctrl.sv
// Parallel-load serializer: accepts a word on valid/ready and shifts it out MSB first,
// one bit per DIV+1 clocks. Define PARITY_EN to append an even-parity bit.
module shift_tx_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 9
) (
    input  logic             clk50m,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic             bit_tick
);

    localparam int unsigned PW = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam logic [PW-1:0] PRESC_RLD = PW'(DIV);
    localparam logic [BW-1:0] BITS_RLD  = BW'(WIDTH);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t            state, state_d;
    logic [WIDTH-1:0]  sr, sr_d;
    logic [PW-1:0]     presc, presc_d;
    logic [BW-1:0]     bitcnt, bitcnt_d;
    logic              tick;
`ifdef PARITY_EN
    logic              parity, parity_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sr     <= '0;
            presc  <= PRESC_RLD;
            bitcnt <= '0;
`ifdef PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            sr     <= sr_d;
            presc  <= presc_d;
            bitcnt <= bitcnt_d;
`ifdef PARITY_EN
            parity <= parity_d;
`endif
        end
    end

    // Bit boundary: only meaningful while a bit is on the wire
    always_comb begin
        busy     = 1'b0;
        in_ready = 1'b0;
        done     = 1'b0;
        sout     = 1'b1;
        case (state)
            IDLE:  in_ready = 1'b1;
            SHIFT: begin
                busy = 1'b1;
                sout = sr[WIDTH-1];
            end
`ifdef PARITY_EN
            PAR: begin
                busy = 1'b1;
                sout = parity;
            end
`endif
            DONE:  done = 1'b1;
            default: ;
        endcase
        tick     = busy && (presc == '0);
        bit_tick = tick;
    end

    // Next-state and datapath update; abort takes priority over the final tick
    always_comb begin
        state_d  = state;
        sr_d     = sr;
        presc_d  = presc;
        bitcnt_d = bitcnt;
`ifdef PARITY_EN
        parity_d = parity;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_d  = SHIFT;
                    sr_d     = in_data;
                    bitcnt_d = BITS_RLD;
                    presc_d  = PRESC_RLD;
`ifdef PARITY_EN
                    parity_d = ^in_data;
`endif
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    presc_d = PRESC_RLD;
                end else if (tick) begin
                    presc_d  = PRESC_RLD;
                    sr_d     = {sr[WIDTH-2:0], 1'b0};
                    bitcnt_d = bitcnt - BW'(1);
                    if (bitcnt == BW'(1)) begin
`ifdef PARITY_EN
                        state_d = PAR;
`else
                        state_d = DONE;
`endif
                    end
                end else begin
                    presc_d = presc - PW'(1);
                end
            end
`ifdef PARITY_EN
            PAR: begin
                if (abort) begin
                    state_d = IDLE;
                    presc_d = PRESC_RLD;
                end else if (tick) begin
                    presc_d = PRESC_RLD;
                    state_d = DONE;
                end else begin
                    presc_d = presc - PW'(1);
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Directed bench for shift_tx_ctrl: reset, table of transfers (incl. back-to-back,
// abort, abort on final tick), async reset mid-transfer, and a DIV=0 instance.
module tb_shift_tx_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DIV   = 9;
`ifdef PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam int LAST = NB * (DIV + 1);

    typedef struct {
        logic [7:0] word;
        int         abort_at;   // 0 = none, -1 = on the final tick
        bit         keep_valid;
        logic [7:0] next_word;
        logic       exp_par;
    } vec_t;

    logic       clk50m;
    logic       rst_n;
    logic       in_valid, in_ready, abort, sout, busy, done, bit_tick;
    logic [7:0] in_data;
    logic       v0, r0, ab0, so0, b0, dn0, t0;
    logic [7:0] d0;

    int n_tests = 0;
    int n_fail  = 0;

    shift_tx_ctrl #(.WIDTH(WIDTH), .DIV(DIV)) u_dut (
        .clk50m(clk50m), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .abort(abort), .sout(sout), .busy(busy), .done(done),
        .bit_tick(bit_tick)
    );

    shift_tx_ctrl #(.WIDTH(WIDTH), .DIV(0)) u_dut0 (
        .clk50m(clk50m), .rst_n(rst_n), .in_valid(v0), .in_ready(r0),
        .in_data(d0), .abort(ab0), .sout(so0), .busy(b0), .done(dn0),
        .bit_tick(t0)
    );

    initial clk50m = 1'b0;
    always #10 clk50m = ~clk50m;

    task automatic chk(input string name, input int cyc, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got %0b want %0b", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk50m);
        #1;
    endtask

    // Starts in the handshake cycle T; returns in cycle T+LAST+2
    task automatic xfer(input vec_t v);
        int   ab;
        bit   aborted;
        int   b;
        logic e_sout, e_busy, e_done, e_rdy, e_tick;
        ab      = (v.abort_at < 0) ? LAST : v.abort_at;
        aborted = 1'b0;
        chk("ready_at_T", 0, in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = v.word;
        for (int k = 1; k <= LAST + 2; k++) begin
            step();
            if (k == 1) begin
                if (v.keep_valid) in_data = v.next_word;
                else              in_valid = 1'b0;
            end
            abort = 1'b0;
            if (ab > 0 && k > ab) aborted = 1'b1;
            if (aborted || k == LAST + 2) begin
                e_sout = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b1; e_tick = 1'b0;
            end else if (k <= LAST) begin
                b      = (k - 1) / (DIV + 1);
                e_sout = (b < WIDTH) ? v.word[WIDTH-1-b] : v.exp_par;
                e_busy = 1'b1; e_done = 1'b0; e_rdy = 1'b0;
                e_tick = ((k % (DIV + 1)) == 0);
            end else begin
                e_sout = 1'b1; e_busy = 1'b0; e_done = 1'b1; e_rdy = 1'b0; e_tick = 1'b0;
            end
            chk("sout", k, sout, e_sout);
            chk("busy", k, busy, e_busy);
            chk("done", k, done, e_done);
            chk("in_ready", k, in_ready, e_rdy);
            chk("bit_tick", k, bit_tick, e_tick);
            if (k == ab) abort = 1'b1;
        end
        abort = 1'b0;
    endtask

    vec_t vecs[8];
    int   ndone;

    initial begin
        vecs[0] = '{8'hA5, 0,  1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'h3C, 0,  1'b1, 8'hFF, 1'b0};
        vecs[2] = '{8'hFF, 0,  1'b0, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 35, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h5A, -1, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{8'h07, 0,  1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h00, 0,  1'b0, 8'h00, 1'b0};
        vecs[7] = '{8'h80, 0,  1'b0, 8'h00, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; abort = 1'b0;
        v0 = 1'b0; d0 = 8'h00; ab0 = 1'b0;

        // Reset values
        repeat (3) step();
        chk("rst_ready", 0, in_ready, 1'b1);
        chk("rst_sout", 0, sout, 1'b1);
        chk("rst_busy", 0, busy, 1'b0);
        chk("rst_done", 0, done, 1'b0);
        chk("rst_tick", 0, bit_tick, 1'b0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_ready", 0, in_ready, 1'b1);
        chk("idle_busy", 0, busy, 1'b0);
        chk("idle_sout", 0, sout, 1'b1);

        foreach (vecs[i]) xfer(vecs[i]);

        // Async reset mid-transfer
        in_valid = 1'b1; in_data = 8'hFF;
        step();
        in_valid = 1'b0;
        repeat (19) step();
        chk("pre_rst_busy", 20, busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sout", 20, sout, 1'b1);
        chk("mid_rst_busy", 20, busy, 1'b0);
        chk("mid_rst_ready", 20, in_ready, 1'b1);
        step();
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (done) ndone++;
        end
        chk("mid_rst_no_done", 0, logic'(ndone != 0), 1'b0);
        chk("mid_rst_idle", 0, in_ready, 1'b1);

        // DIV=0: one bit per clock, tick suppressed in IDLE
        chk("div0_idle_tick", 0, t0, 1'b0);
        chk("div0_idle_ready", 0, r0, 1'b1);
        v0 = 1'b1; d0 = 8'h81;
        for (int k = 1; k <= NB + 2; k++) begin
            step();
            if (k == 1) v0 = 1'b0;
            if (k <= WIDTH) begin
                chk("div0_sout", k, so0, d0[WIDTH-k]);
                chk("div0_tick", k, t0, 1'b1);
                chk("div0_busy", k, b0, 1'b1);
            end else if (k <= NB) begin
                chk("div0_par", k, so0, 1'b0);
                chk("div0_tick", k, t0, 1'b1);
            end else if (k == NB + 1) begin
                chk("div0_done", k, dn0, 1'b1);
                chk("div0_sout_done", k, so0, 1'b1);
            end else begin
                chk("div0_done_off", k, dn0, 1'b0);
                chk("div0_ready", k, r0, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
